axis_frame_sink: RTL and testbench

Synthesizable AXI4-Stream video receiver: the consuming end of the pixel generator's output stream. It drives `tready` according to a selectable back-pressure policy, tracks word and line position, checks SOF (`tuser`) and EOL (`tlast`) framing against the configured frame geometry, and reports framing errors, position and frame counts as registered outputs. It sits downstream of `pixel_generator`, in place of the VDMA, for on-chip self-test and simulation benches.

---
 rtl/axis_sink_pkg.sv | 40 ++++
 rtl/axis_frame_sink_if.sv | 26 ++
 rtl/axis_ready_gen.sv | 44 ++++
 rtl/axis_frame_sink.sv | 177 +++++++++++++++++
 tb/tb_axis_frame_sink.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_sink_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_sink_pkg
//  Description : Shared definitions for the AXI4-Stream frame sink.
//                Contents: ready-policy selectors, the framing FSM state
//                type, error bit positions and an error-weight helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_sink_pkg;

    // Back-pressure policy selectors (values of READY_MODE)
    localparam int c_READY_ALWAYS      = 1;
    localparam int c_READY_PRBS        = 2;
    localparam int c_READY_AFTER_VALID = 3;

    // Error flag bit positions
    localparam int ERR_SOF_MISSING    = 0;
    localparam int ERR_SOF_UNEXPECTED = 1;
    localparam int ERR_EOL_MISSING    = 2;
    localparam int ERR_EOL_UNEXPECTED = 3;
    localparam int ERR_TIMEOUT        = 4;
    localparam int ERR_W              = 5;

    typedef enum logic [0:0] {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Number of error events raised in one cycle
    function automatic logic [2:0] err_weight(input logic [ERR_W-1:0] e);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < ERR_W; i++) begin
            n = n + {2'b00, e[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_sink_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_sink_if
//  Description : AXI4-Stream video bus (data, valid, SOF, EOL, ready).
//                master : stream source, drives data/valid/user/last
//                slave  : stream sink, drives ready
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_frame_sink_if;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tuser;
    logic        s_tlast;
    logic        s_tready;

    modport master (
        output s_tdata, s_tvalid, s_tuser, s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tuser, s_tlast,
        output s_tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_ready_gen.sv
`default_nettype none
// ============================================================================
//  Module      : axis_ready_gen
//  Description : Registered tready generator with selectable policy:
//                always ready, PRBS pseudo-random, or ready-after-valid.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_tvalid     - stream valid (used by ready-after-valid)
//                o_tready     - registered ready
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_ready_gen
    import axis_sink_pkg::*;
#(
    parameter int          READY_MODE = 1,
    parameter logic [32:0] RND_SEED   = 33'd1246504138
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_tvalid,
    output logic      o_tready
);

    logic [32:0] r_prbs;
    logic        r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prbs  <= RND_SEED;
            r_ready <= 1'b0;
        end else begin
            r_prbs <= {r_prbs[31:0], r_prbs[32] ^ ~r_prbs[19]};
            case (READY_MODE)
                c_READY_PRBS:        r_ready <= r_prbs[32];
                // Toggles while valid is held, so no two consecutive beats
                c_READY_AFTER_VALID: r_ready <= i_tvalid && !r_ready;
                default:             r_ready <= 1'b1;
            endcase
        end
    end

    assign o_tready = r_ready;

endmodule
`default_nettype wire

// File: rtl/axis_frame_sink.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_sink
//  Description : AXI4-Stream video sink. Applies back-pressure, tracks
//                word/line position, checks SOF/EOL framing against
//                X_SIZE x Y_SIZE and reports sticky/pulsed errors.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                s_axis (slave)  - video stream in, tready out
//                clr_err         - clear err_flags / err_count
//                x_pos, y_pos    - position expected next
//                frame_cnt       - frames started (wraps)
//                frame_done      - pulse on frame completion
//                err_flags/pulse - sticky / one-cycle error bits
//                err_count       - saturating error event count
//                frame_sum       - per-frame data sum
//  Options     : AXIS_FRAME_SUM_EN - build the frame_sum accumulator;
//                otherwise frame_sum is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_sink
    import axis_sink_pkg::*;
#(
    parameter int          X_SIZE     = 480,
    parameter int          Y_SIZE     = 480,
    parameter int          TIMEOUT    = 1000,
    parameter int          READY_MODE = 1,
    parameter logic [32:0] RND_SEED   = 33'd1246504138
) (
    input  wire logic          clk,
    input  wire logic          rst,
    axis_frame_sink_if.slave   s_axis,
    input  wire logic          clr_err,
    output logic [15:0]        x_pos,
    output logic [15:0]        y_pos,
    output logic [15:0]        frame_cnt,
    output logic               frame_done,
    output logic [ERR_W-1:0]   err_flags,
    output logic [ERR_W-1:0]   err_pulse,
    output logic [15:0]        err_count,
    output logic [31:0]        frame_sum
);

    state_t           r_state, w_state_next;
    logic             w_tready, w_beat, w_sof, w_proc, w_line_adv, w_frame_end, w_to_hit;
    logic [15:0]      w_x_cur, w_y_cur, w_cnt_base;
    logic [16:0]      w_cnt_sum;
    logic [ERR_W-1:0] w_err;
    logic [15:0]      r_x, r_y, r_frame_cnt, r_err_count;
    logic             r_frame_done;
    logic [ERR_W-1:0] r_err_flags, r_err_pulse;
    logic [31:0]      r_to_cnt;

    axis_ready_gen #(
        .READY_MODE (READY_MODE),
        .RND_SEED   (RND_SEED)
    ) u_ready_gen (
        .clk      (clk),
        .rst      (rst),
        .i_tvalid (s_axis.s_tvalid),
        .o_tready (w_tready)
    );

    assign s_axis.s_tready = w_tready;
    assign w_beat          = s_axis.s_tvalid && w_tready;

    // Timeout counter hits on the TIMEOUT-th consecutive idle cycle
    assign w_to_hit = !s_axis.s_tvalid && ((r_to_cnt + 32'd1) == 32'(TIMEOUT));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_SYNC;
        else     r_state <= w_state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        if (w_frame_end)  w_state_next = ST_SYNC;
        else if (w_sof)   w_state_next = ST_ACTIVE;
    end

    // ---------------- FSM: beat decode ----------------
    // SOF handling first (it may reset the position), then the EOL check
    // runs against the possibly-reset position.
    always_comb begin
        w_sof  = 1'b0;
        w_proc = 1'b0;
        w_err  = '0;
        if (w_beat) begin
            if (s_axis.s_tuser) begin
                w_sof  = 1'b1;
                w_proc = 1'b1;
                if (r_state == ST_ACTIVE) w_err[ERR_SOF_UNEXPECTED] = 1'b1;
            end else if (r_state == ST_SYNC) begin
                w_err[ERR_SOF_MISSING] = 1'b1;
            end else begin
                w_proc = 1'b1;
            end
        end
        w_x_cur    = w_sof ? 16'd0 : r_x;
        w_y_cur    = w_sof ? 16'd0 : r_y;
        w_line_adv = w_proc && s_axis.s_tlast;
        if (w_proc && (w_x_cur == 16'(X_SIZE - 1)) && !s_axis.s_tlast)
            w_err[ERR_EOL_MISSING] = 1'b1;
        if (w_proc && (w_x_cur != 16'(X_SIZE - 1)) && s_axis.s_tlast)
            w_err[ERR_EOL_UNEXPECTED] = 1'b1;
        w_frame_end = w_line_adv && (w_y_cur == 16'(Y_SIZE - 1));
        w_err[ERR_TIMEOUT] = w_to_hit;
    end

    // A same-cycle error survives clr_err because it is OR-ed in after the clear
    assign w_cnt_base = clr_err ? 16'd0 : r_err_count;
    assign w_cnt_sum  = {1'b0, w_cnt_base} + {14'd0, err_weight(w_err)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x          <= '0;
            r_y          <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
            r_err_flags  <= '0;
            r_err_pulse  <= '0;
            r_err_count  <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_frame_done <= w_frame_end;
            r_err_pulse  <= w_err;
            r_err_flags  <= (clr_err ? '0 : r_err_flags) | w_err;
            r_err_count  <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
            if (w_sof) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_proc) begin
                if (w_line_adv) begin
                    r_x <= 16'd0;
                    r_y <= w_frame_end ? 16'd0 : w_y_cur + 16'd1;
                end else begin
                    r_x <= (w_x_cur == 16'hFFFF) ? w_x_cur : w_x_cur + 16'd1;
                    r_y <= w_y_cur;
                end
            end
            if (s_axis.s_tvalid || w_to_hit) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    assign x_pos      = r_x;
    assign y_pos      = r_y;
    assign frame_cnt  = r_frame_cnt;
    assign frame_done = r_frame_done;
    assign err_flags  = r_err_flags;
    assign err_pulse  = r_err_pulse;
    assign err_count  = r_err_count;

`ifdef AXIS_FRAME_SUM_EN
    logic [31:0] r_acc, r_sum, w_acc_next;

    // Restarts on SOF so a resync begins a fresh sum
    assign w_acc_next = (w_sof ? 32'd0 : r_acc) + s_axis.s_tdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_sum <= '0;
        end else begin
            if (w_proc)      r_acc <= w_acc_next;
            if (w_frame_end) r_sum <= w_acc_next;
        end
    end

    assign frame_sum = r_sum;
`else
    logic w_unused_tdata;
    assign w_unused_tdata = ^s_axis.s_tdata;
    assign frame_sum      = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_frame_sink
//  Description : Bench for axis_frame_sink. Three sinks (ready modes 1/2/3,
//                X_SIZE=4, Y_SIZE=2, TIMEOUT=1000) are compared every cycle
//                against a behavioural model; sink 0 gets directed framing
//                scenarios, sinks 1 and 2 get random-gapped clean frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_sink;

    localparam int          c_X    = 4;
    localparam int          c_Y    = 2;
    localparam int          c_TO   = 1000;
    localparam logic [32:0] c_SEED = 33'd1246504138;
    localparam int          c_NBEATS = 80;   // 10 frames of 8 words

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Stimulus (written by the main process only)
    logic [31:0] d_data  [3];
    logic        d_valid [3];
    logic        d_user  [3];
    logic        d_last  [3];
    logic        d_clr   [3];

    // DUT outputs
    logic [2:0][15:0] o_x, o_y, o_fc, o_cnt;
    logic [2:0]       o_fd, o_rdy;
    logic [2:0][4:0]  o_flags, o_pulse;
    logic [2:0][31:0] o_sum;

    axis_frame_sink_if ifc [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign ifc[g].s_tdata  = d_data[g];
        assign ifc[g].s_tvalid = d_valid[g];
        assign ifc[g].s_tuser  = d_user[g];
        assign ifc[g].s_tlast  = d_last[g];
        assign o_rdy[g]        = ifc[g].s_tready;

        axis_frame_sink #(
            .X_SIZE     (c_X),
            .Y_SIZE     (c_Y),
            .TIMEOUT    (c_TO),
            .READY_MODE (g + 1),
            .RND_SEED   (c_SEED)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .s_axis     (ifc[g]),
            .clr_err    (d_clr[g]),
            .x_pos      (o_x[g]),
            .y_pos      (o_y[g]),
            .frame_cnt  (o_fc[g]),
            .frame_done (o_fd[g]),
            .err_flags  (o_flags[g]),
            .err_pulse  (o_pulse[g]),
            .err_count  (o_cnt[g]),
            .frame_sum  (o_sum[g])
        );
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int d, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=0x%0h expected=0x%0h", name, d, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: position/frame bookkeeping per sink
    // ------------------------------------------------------------------
    int unsigned m_x [3], m_y [3], m_to [3], m_cnt [3];
    logic [15:0] m_fc [3];
    logic        m_fd [3], m_act [3], m_rdy [3];
    logic [4:0]  m_flags [3], m_pulse [3];
    logic [31:0] m_acc [3], m_sum [3];
    logic [32:0] m_prbs [3];

    task automatic model_step(input int d);
        logic       beat, proc;
        logic [4:0] e;
        int unsigned n;
        if (rst) begin
            m_x[d] = 0; m_y[d] = 0; m_to[d] = 0; m_cnt[d] = 0; m_fc[d] = 0;
            m_fd[d] = 0; m_act[d] = 0; m_rdy[d] = 0; m_flags[d] = 0; m_pulse[d] = 0;
            m_acc[d] = 0; m_sum[d] = 0; m_prbs[d] = c_SEED;
            return;
        end
        e = 5'd0;
        m_fd[d] = 1'b0;
        beat = d_valid[d] && m_rdy[d];
        proc = 1'b0;
        if (beat) begin
            if (d_user[d]) begin
                if (m_act[d]) e[1] = 1'b1;
                m_act[d] = 1'b1; m_fc[d] = m_fc[d] + 16'd1;
                m_x[d] = 0; m_y[d] = 0; m_acc[d] = 0;
                proc = 1'b1;
            end else if (!m_act[d]) begin
                e[0] = 1'b1;
            end else begin
                proc = 1'b1;
            end
        end
        if (proc) begin
            m_acc[d] = m_acc[d] + d_data[d];
            if (m_x[d] == c_X - 1 && !d_last[d]) e[2] = 1'b1;
            if (m_x[d] != c_X - 1 && d_last[d])  e[3] = 1'b1;
            if (d_last[d]) begin
                m_x[d] = 0;
                m_y[d] = m_y[d] + 1;
                if (m_y[d] == c_Y) begin
                    m_y[d] = 0; m_fd[d] = 1'b1; m_act[d] = 1'b0; m_sum[d] = m_acc[d];
                end
            end else if (m_x[d] != 65535) begin
                m_x[d] = m_x[d] + 1;
            end
        end
        if (d_valid[d]) m_to[d] = 0;
        else begin
            m_to[d] = m_to[d] + 1;
            if (m_to[d] == c_TO) begin e[4] = 1'b1; m_to[d] = 0; end
        end
        m_pulse[d] = e;
        m_flags[d] = (d_clr[d] ? 5'd0 : m_flags[d]) | e;
        n = (d_clr[d] ? 0 : m_cnt[d]) + $countones(e);
        m_cnt[d] = (n > 65535) ? 65535 : n;
        case (d + 1)
            2: begin
                m_rdy[d]  = m_prbs[d][32];
                m_prbs[d] = {m_prbs[d][31:0], m_prbs[d][32] ^ ~m_prbs[d][19]};
            end
            3:       m_rdy[d] = d_valid[d] && !m_rdy[d];
            default: m_rdy[d] = 1'b1;
        endcase
    endtask

    function automatic logic [31:0] exp_sum(input int d);
`ifdef AXIS_FRAME_SUM_EN
        return m_sum[d];
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        for (int d = 0; d < 3; d++) begin
            m_x[d] = 0; m_y[d] = 0; m_to[d] = 0; m_cnt[d] = 0; m_fc[d] = 0;
            m_fd[d] = 0; m_act[d] = 0; m_rdy[d] = 0; m_flags[d] = 0; m_pulse[d] = 0;
            m_acc[d] = 0; m_sum[d] = 0; m_prbs[d] = c_SEED;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 3; d++) model_step(d);
        end
    end

    // ------------------------------------------------------------------
    // Compare process: every negedge, every sink
    // ------------------------------------------------------------------
    int seen_fd0 = 0, seen_sofm0 = 0, seen_to0 = 0;

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("x_pos",      d, o_x[d],     m_x[d]);
                chk("y_pos",      d, o_y[d],     m_y[d]);
                chk("frame_cnt",  d, o_fc[d],    m_fc[d]);
                chk("frame_done", d, o_fd[d],    m_fd[d]);
                chk("err_flags",  d, o_flags[d], m_flags[d]);
                chk("err_pulse",  d, o_pulse[d], m_pulse[d]);
                chk("err_count",  d, o_cnt[d],   m_cnt[d]);
                chk("frame_sum",  d, o_sum[d],   exp_sum(d));
                chk("s_tready",   d, o_rdy[d],   m_rdy[d]);
            end
            if (o_fd[0])       seen_fd0++;
            if (o_pulse[0][0]) seen_sofm0++;
            if (o_pulse[0][4]) seen_to0++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int   s_idx  [3];
    logic s_pend [3];
    logic s_go   = 1'b0;
    logic s_prev2 = 1'b0;
    int   s_viol = 0;

    // One cycle: wait for the negedge and advance the random streams of
    // sinks 1 and 2; valid is held until the sink accepts the word.
    task automatic step();
        @(negedge clk);
        for (int d = 1; d < 3; d++) begin
            if (s_pend[d]) begin
                s_idx[d]   = s_idx[d] + 1;
                d_valid[d] = 1'b0;
            end
            if (s_go && !d_valid[d] && s_idx[d] < c_NBEATS && $urandom_range(3) != 0) begin
                d_valid[d] = 1'b1;
                d_data[d]  = $urandom;
                d_user[d]  = (s_idx[d] % 8) == 0;
                d_last[d]  = (s_idx[d] % 4) == 3;
            end
            s_pend[d] = d_valid[d] && o_rdy[d];
            if (d == 2) begin
                if (s_pend[d] && s_prev2) s_viol++;
                s_prev2 = s_pend[d];
            end
        end
    endtask

    task automatic beat0(input logic u, input logic l, input logic [31:0] dat);
        step();
        d_valid[0] = 1'b1; d_user[0] = u; d_last[0] = l; d_data[0] = dat; d_clr[0] = 1'b0;
    endtask

    task automatic idle0(input int n);
        repeat (n) begin
            step();
            d_valid[0] = 1'b0; d_user[0] = 1'b0; d_last[0] = 1'b0; d_clr[0] = 1'b0;
        end
    endtask

    task automatic clr0();
        step();
        d_valid[0] = 1'b0; d_user[0] = 1'b0; d_last[0] = 1'b0; d_clr[0] = 1'b1;
    endtask

    task automatic frame0();
        for (int y = 0; y < c_Y; y++)
            for (int x = 0; x < c_X; x++)
                beat0(x == 0 && y == 0, x == c_X - 1, 32'(x));
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            d_data[d] = 0; d_valid[d] = 0; d_user[d] = 0; d_last[d] = 0; d_clr[d] = 0;
            s_idx[d] = 0; s_pend[d] = 0;
        end
        rst = 1'b1;
        repeat (3) step();
        chk("rst_x_pos",     0, o_x[0],     0);
        chk("rst_frame_cnt", 0, o_fc[0],    0);
        chk("rst_err_flags", 0, o_flags[0], 0);
        chk("rst_tready",    0, o_rdy[0],   0);
        rst  = 1'b0;
        s_go = 1'b1;
        idle0(2);

        // Two clean frames, data = x index
        frame0();
        frame0();
        idle0(2);
        chk("clean_frame_cnt", 0, o_fc[0], 2);
        chk("clean_err_flags", 0, o_flags[0], 0);
        chk("clean_done_pulses", 0, seen_fd0, 2);
`ifdef AXIS_FRAME_SUM_EN
        chk("clean_frame_sum", 0, o_sum[0], 12);
`else
        chk("clean_frame_sum", 0, o_sum[0], 0);
`endif

        // First beat without SOF is dropped
        beat0(1'b0, 1'b0, 32'd7);
        idle0(2);
        chk("sofm_flags", 0, o_flags[0], 5'b00001);
        chk("sofm_pulses", 0, seen_sofm0, 1);
        chk("sofm_x_pos", 0, o_x[0], 0);
        frame0();
        idle0(2);
        chk("sofm_frame_cnt", 0, o_fc[0], 3);
        chk("sofm_done_pulses", 0, seen_fd0, 3);
        clr0();

        // tlast withheld on word 3, asserted on word 5
        beat0(1'b1, 1'b0, 32'd0);
        beat0(1'b0, 1'b0, 32'd1);
        beat0(1'b0, 1'b0, 32'd2);
        beat0(1'b0, 1'b0, 32'd3);
        beat0(1'b0, 1'b0, 32'd4);
        beat0(1'b0, 1'b1, 32'd5);
        idle0(2);
        chk("eol_y_pos", 0, o_y[0], 1);
        chk("eol_x_pos", 0, o_x[0], 0);
        chk("eol_err_count", 0, o_cnt[0], 2);
        chk("eol_flags", 0, o_flags[0], 5'b01100);
        for (int x = 0; x < c_X; x++) beat0(1'b0, x == c_X - 1, 32'(x));
        idle0(2);
        chk("eol_frame_cnt", 0, o_fc[0], 4);
        clr0();

        // SOF on word 2 of line 1
        for (int x = 0; x < c_X; x++) beat0(x == 0, x == c_X - 1, 32'(x));
        beat0(1'b0, 1'b0, 32'd0);
        beat0(1'b0, 1'b0, 32'd1);
        beat0(1'b1, 1'b0, 32'd2);
        idle0(2);
        chk("sofu_x_pos", 0, o_x[0], 1);
        chk("sofu_y_pos", 0, o_y[0], 0);
        chk("sofu_frame_cnt", 0, o_fc[0], 6);
        chk("sofu_flags", 0, o_flags[0], 5'b00010);
        clr0();
        idle0(1);
        chk("clr_flags", 0, o_flags[0], 0);
        chk("clr_err_count", 0, o_cnt[0], 0);
        beat0(1'b0, 1'b0, 32'd1);
        beat0(1'b0, 1'b0, 32'd2);
        beat0(1'b0, 1'b1, 32'd3);
        for (int x = 0; x < c_X; x++) beat0(1'b0, x == c_X - 1, 32'(x));
        idle0(2);
        chk("sofu_done_pulses", 0, seen_fd0, 5);

        // Random-gapped streams on sinks 1 and 2
        begin
            int i;
            for (i = 0; i < 5000 && !(s_idx[1] == c_NBEATS && s_idx[2] == c_NBEATS); i++) idle0(1);
            chk("stream_done", 1, (s_idx[1] == c_NBEATS && s_idx[2] == c_NBEATS), 1);
        end
        idle0(3);
        for (int d = 1; d < 3; d++) begin
            chk("stream_frame_cnt", d, o_fc[d], 10);
            chk("stream_err_flags", d, o_flags[d], 0);
            chk("stream_err_count", d, o_cnt[d], 0);
        end
        chk("mode3_consecutive_beats", 2, s_viol, 0);

        // Timeout: 2500 idle cycles
        beat0(1'b1, 1'b0, 32'd0);
        seen_to0 = 0;
        clr0();
        idle0(2499);
        idle0(2);
        chk("timeout_pulses", 0, seen_to0, 2);
        chk("timeout_err_count", 0, o_cnt[0], 2);
        chk("timeout_flags", 0, o_flags[0], 5'b10000);

        // Reset mid-frame discards the partial frame silently
        beat0(1'b1, 1'b0, 32'd0);
        rst = 1'b1;
        idle0(2);
        chk("midrst_x_pos", 0, o_x[0], 0);
        chk("midrst_frame_cnt", 0, o_fc[0], 0);
        chk("midrst_err_count", 0, o_cnt[0], 0);
        rst = 1'b0;
        idle0(3);
        frame0();
        idle0(2);
        chk("post_rst_frame_cnt", 0, o_fc[0], 1);
        chk("post_rst_flags", 0, o_flags[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
